// File: rtl/bot_permutation_filter_pkg.sv
// Shared constants and the block-index permutation helper
// for the bot permutation filter.
package bot_permutation_filter_pkg;

  localparam int BOT_WIDTH  = 128;
  localparam int NUM_PERMS  = 6;
  localparam int NUM_BLOCKS = 8;
  localparam int BLOCK_W    = 16;

  localparam logic [2:0] PERM_ABC = 3'd5;
  localparam logic [2:0] PERM_ACB = 3'd4;
  localparam logic [2:0] PERM_BAC = 3'd3;
  localparam logic [2:0] PERM_BCA = 3'd2;
  localparam logic [2:0] PERM_CAB = 3'd1;
  localparam logic [2:0] PERM_CBA = 3'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Source block feeding output block idx = {a,b,c}
  function automatic logic [2:0] permute_block_index(
    input logic [2:0] perm,
    input logic [2:0] idx
  );
    logic       a;
    logic       b;
    logic       c;
    logic [2:0] r;
    {a, b, c} = idx;
    case (perm)
      PERM_ACB: r = {a, c, b};
      PERM_BAC: r = {b, a, c};
      PERM_BCA: r = {b, c, a};
      PERM_CAB: r = {c, a, b};
      PERM_CBA: r = {c, b, a};
      default:  r = idx;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bot_permute_subset_check.sv
// Per-block subset test of one permuted bot against top.
// blk_ok[j] = (perm(bot) block j & ~top block j) == 0.
module bot_permute_subset_check
  import bot_permutation_filter_pkg::*;
#(
  parameter logic [2:0] PERM = PERM_ABC
) (
  input  logic [BOT_WIDTH-1:0]  bot,
  input  logic [BOT_WIDTH-1:0]  top,
  output logic [NUM_BLOCKS-1:0] blk_ok
);

  always_comb begin
    blk_ok = '0;
    for (int j = 0; j < NUM_BLOCKS; j++) begin
      blk_ok[j] = ~|(
        bot[{permute_block_index(PERM, 3'(j)), 4'b0000} +: BLOCK_W]
        & ~top[j*BLOCK_W +: BLOCK_W]);
    end
  end

endmodule

// File: rtl/bot_permutation_filter.sv
// Three-stage bot filter: checks each bot against top under six
// variable permutations and throttles intake from FIFO fill level.
module bot_permutation_filter
  import bot_permutation_filter_pkg::*;
#(
  parameter int EXTRA_DATA_WIDTH = 12,
  parameter int FIFO_LIMIT       = 26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BOT_WIDTH-1:0]        topIn,
  input  logic                        loadTop,
  input  logic [BOT_WIDTH-1:0]        botIn,
  input  logic                        botInValid,
  input  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  output logic                        botInReady,
  input  logic [4:0]                  fifoFullness,
  output logic [BOT_WIDTH-1:0]        bot,
  output logic                        anyBotPermutIsValid,
  output logic [NUM_PERMS-1:0]        validBotPermutesOut,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataOut,
  output logic [31:0]                 botsAccepted,
  output logic [31:0]                 botsDropped
);

  localparam int EW = EXTRA_DATA_WIDTH;

  typedef logic [NUM_PERMS-1:0][NUM_BLOCKS-1:0] flags_t;

  state_e               state_q, state_d;
  logic [BOT_WIDTH-1:0] top_q, top_d;
  logic [BOT_WIDTH-1:0] hold_q, hold_d;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [BOT_WIDTH-1:0] bot1_q, bot1_d, bot2_q, bot2_d;
  logic [BOT_WIDTH-1:0] bot3_q, bot3_d;
  logic [EW-1:0]        ext1_q, ext1_d, ext2_q, ext2_d;
  logic [EW-1:0]        ext3_q, ext3_d;
  flags_t               flags_c, flags2_q, flags2_d;
  logic [NUM_PERMS-1:0] mask_c, mask3_q, mask3_d;
  logic                 any3_q, any3_d;
  logic [31:0]          acc_q, acc_d, drop_q, drop_d;
  logic [1:0]           occ;
  logic                 fits;
  logic                 accept;

  assign occ  = 2'(v1_q) + 2'(v2_q) + 2'(v3_q);
  assign fits = ({1'b0, fifoFullness} + {4'b0000, occ})
                <= 6'(FIFO_LIMIT);

  // Reset term keeps ready low while rst is held
  assign botInReady = rst & (state_q == ST_RUN) & ~loadTop & fits;
  assign accept     = botInValid & botInReady;

  for (genvar p = 0; p < NUM_PERMS; p++) begin : g_perm
    bot_permute_subset_check #(
      .PERM(3'(p))
    ) u_chk (
      .bot   (bot1_q),
      .top   (top_q),
      .blk_ok(flags_c[p])
    );
  end

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_RUN: begin
        if (loadTop) begin
          if (occ == 2'd0) begin
            top_d = topIn;
          end else begin
            hold_d  = topIn;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (loadTop) hold_d = topIn;
        if (occ == 2'd0) begin
          top_d   = hold_d;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    mask_c = '0;
    for (int p = 0; p < NUM_PERMS; p++) begin
      mask_c[p] = &flags2_q[p];
    end
    v1_d     = accept;
    bot1_d   = accept ? botIn : bot1_q;
    ext1_d   = accept ? extraDataIn : ext1_q;
    v2_d     = v1_q;
    bot2_d   = v1_q ? bot1_q : bot2_q;
    ext2_d   = v1_q ? ext1_q : ext2_q;
    flags2_d = v1_q ? flags_c : flags2_q;
    v3_d     = v2_q;
    bot3_d   = v2_q ? bot2_q : bot3_q;
    ext3_d   = v2_q ? ext2_q : ext3_q;
    mask3_d  = v2_q ? mask_c : mask3_q;
    any3_d   = v2_q & |mask_c;
    acc_d    = acc_q + 32'(v2_q);
    drop_d   = drop_q + 32'(v2_q & ~|mask_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      top_q    <= '0;
      hold_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      bot1_q   <= '0;
      bot2_q   <= '0;
      bot3_q   <= '0;
      ext1_q   <= '0;
      ext2_q   <= '0;
      ext3_q   <= '0;
      flags2_q <= '0;
      mask3_q  <= '0;
      any3_q   <= 1'b0;
      acc_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      top_q    <= top_d;
      hold_q   <= hold_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      bot1_q   <= bot1_d;
      bot2_q   <= bot2_d;
      bot3_q   <= bot3_d;
      ext1_q   <= ext1_d;
      ext2_q   <= ext2_d;
      ext3_q   <= ext3_d;
      flags2_q <= flags2_d;
      mask3_q  <= mask3_d;
      any3_q   <= any3_d;
      acc_q    <= acc_d;
      drop_q   <= drop_d;
    end
  end

  assign bot                 = bot3_q;
  assign extraDataOut        = ext3_q;
  assign validBotPermutesOut = mask3_q;
  assign anyBotPermutIsValid = any3_q;
  assign botsAccepted        = acc_q;
  assign botsDropped         = drop_q;

endmodule
